// File: rtl/bus_timer_if.sv
// Core-side register bus for the bus_timer peripheral: address/data/strobe
// from the core, combinational read data and level interrupt back.
interface bus_timer_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_write;
    logic [31:0] bus_rdata;
    logic        irq;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_write,
        input  bus_rdata,
        input  irq
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_write,
        output bus_rdata,
        output irq
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped prescaled up-counter with compare match, optional auto-reload
// and a level interrupt; 16-byte register window at BASE_ADDR.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input logic        clk,
    input logic        reset,
    bus_timer_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0] IDX_CTRL     = 2'd0;
    localparam logic [1:0] IDX_PRESCALE = 2'd1;
    localparam logic [1:0] IDX_COUNT    = 2'd2;
    localparam logic [1:0] IDX_COMPARE  = 2'd3;

    logic              en;
    logic              auto_reload;
    logic              irq_en;
    logic              match;
    logic [DATA_W-1:0] prescale;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;
    logic [DATA_W-1:0] pre_cnt;

    logic              sel;
    logic [1:0]        idx;
    logic              wr;
    logic              tick;
    logic              hit;
    logic [DATA_W-1:0] rdata_c;
    logic              unused_addr_bits;

    assign sel  = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
    assign idx  = bus.bus_addr[3:2];
    assign wr   = sel && bus.bus_write;
    assign tick = en && (pre_cnt == prescale);
    // Uses the pre-write COMPARE, so a same-cycle COMPARE write cannot affect this match.
    assign hit  = tick && (count == compare);

    assign unused_addr_bits = ^bus.bus_addr[1:0];

    // Zero-wait read mux; no side effects.
    always_comb begin
        rdata_c = '0;
        if (sel) begin
            case (idx)
                IDX_CTRL:     rdata_c = {23'd0, match, 5'd0, irq_en, auto_reload, en};
                IDX_PRESCALE: rdata_c = prescale;
                IDX_COUNT:    rdata_c = count;
                IDX_COMPARE:  rdata_c = compare;
                default:      rdata_c = '0;
            endcase
        end
    end

    assign bus.bus_rdata = rdata_c;
    assign bus.irq       = match && irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            match       <= 1'b0;
            prescale    <= '0;
            count       <= '0;
            compare     <= '0;
            pre_cnt     <= '0;
        end else begin
            if (wr && idx == IDX_CTRL) begin
                en          <= bus.bus_wdata[0];
                auto_reload <= bus.bus_wdata[1];
                irq_en      <= bus.bus_wdata[2];
            end

            // A new match beats a simultaneous write-1-to-clear.
            if (hit) begin
                match <= 1'b1;
            end else if (wr && idx == IDX_CTRL && bus.bus_wdata[8]) begin
                match <= 1'b0;
            end

            if (wr && idx == IDX_PRESCALE) begin
                prescale <= bus.bus_wdata;
            end

            if (wr && idx == IDX_COMPARE) begin
                compare <= bus.bus_wdata;
            end

            if (wr && idx == IDX_PRESCALE) begin
                pre_cnt <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
            end else if (en) begin
                pre_cnt <= pre_cnt + DATA_W'(1);
            end

            // Bus write to COUNT overrides both reload and increment.
            if (wr && idx == IDX_COUNT) begin
                count <= bus.bus_wdata;
            end else if (hit && auto_reload) begin
                count <= '0;
            end else if (tick) begin
                count <= count + DATA_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bus_timer.sv
// Scenario-driven bench for bus_timer: expected values are queued as stimulus
// is applied and popped when the corresponding output is sampled.
module tb_bus_timer;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'd4;
    localparam logic [31:0] A_CNT  = BASE + 32'd8;
    localparam logic [31:0] A_CMP  = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp_v;

    bus_timer_if bus_if ();

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Tasks are entered and left at posedge+1; reads stay within that cycle.
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_write = 1'b0;
        #1;
        d = bus_if.bus_rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        bus_if.bus_write = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_write = 1'b0;
        bus_if.bus_addr  = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] regs[4];
        regs = '{A_CTRL, A_PRE, A_CNT, A_CMP};
        reset = 1'b1;
        idle(2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL reset_during_cnt: got %h expected %h", got, exp_v); end
        rd(BASE + 32'h10, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL reset_during_unsel: got %h expected %h", got, exp_v); end
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(regs[i], got); exp_v = exp_q.pop_front(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL reset_reg%0d: got %h expected %h", i, got, exp_v); end
        end
        got = 32'(bus_if.irq); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL reset_irq: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_prescale_match();
        wr(A_PRE, 32'd3);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h7);
        exp_q.push_back(32'd0);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_cnt_start: got %h expected %h", got, exp_v); end
        idle(3);
        exp_q.push_back(32'd0);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_cnt_pretick: got %h expected %h", got, exp_v); end
        idle(1);
        for (int t = 1; t <= 5; t++) begin
            if (t > 1) idle(4);
            exp_q.push_back(32'(t));
            exp_q.push_back(32'd0);
            rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL pm_cnt_tick%0d: got %h expected %h", t, got, exp_v); end
            got = 32'(bus_if.irq); exp_v = exp_q.pop_front(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL pm_irq_tick%0d: got %h expected %h", t, got, exp_v); end
        end
        idle(3);
        exp_q.push_back(32'h7);
        rd(A_CTRL, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_ctrl_prematch: got %h expected %h", got, exp_v); end
        idle(1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h107);
        exp_q.push_back(32'd1);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_cnt_reload: got %h expected %h", got, exp_v); end
        rd(A_CTRL, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_ctrl_match: got %h expected %h", got, exp_v); end
        got = 32'(bus_if.irq); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_irq_match: got %h expected %h", got, exp_v); end
        wr(A_CTRL, 32'h107);
        exp_q.push_back(32'h7);
        exp_q.push_back(32'd0);
        rd(A_CTRL, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_ctrl_cleared: got %h expected %h", got, exp_v); end
        got = 32'(bus_if.irq); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_irq_cleared: got %h expected %h", got, exp_v); end
        idle(3);
        exp_q.push_back(32'd1);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL pm_cnt_continue: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_wrap();
        wr(A_CTRL, 32'h100);
        wr(A_PRE, 32'd0);
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'h10);
        wr(A_CTRL, 32'h1);
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(1);
            rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL wrap_cnt%0d: got %h expected %h", i, got, exp_v); end
        end
        exp_q.push_back(32'h1);
        rd(A_CTRL, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL wrap_ctrl: got %h expected %h", got, exp_v); end
        // Disabling edge is still an enabled tick cycle: 1 -> 2, then frozen.
        wr(A_CTRL, 32'h0);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h2);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL hold_cnt_a: got %h expected %h", got, exp_v); end
        idle(5);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL hold_cnt_b: got %h expected %h", got, exp_v); end
    endtask

    task automatic test_collisions();
        wr(A_CTRL, 32'h1);
        wr(A_CNT, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h101);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL col_cnt_write: got %h expected %h", got, exp_v); end
        idle(1);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL col_cnt_after: got %h expected %h", got, exp_v); end
        wr(A_CTRL, 32'h100);
        wr(A_CNT, 32'h20);
        wr(A_CMP, 32'h22);
        wr(A_CTRL, 32'h5);
        idle(2);
        exp_q.push_back(32'h22);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL col_cnt_prematch: got %h expected %h", got, exp_v); end
        wr(A_CTRL, 32'h105);
        exp_q.push_back(32'h105);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h23);
        rd(A_CTRL, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL col_w1c_vs_set: got %h expected %h", got, exp_v); end
        got = 32'(bus_if.irq); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL col_irq: got %h expected %h", got, exp_v); end
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL col_cnt_noreload: got %h expected %h", got, exp_v); end
        wr(A_CTRL, 32'h100);
        wr(A_CTRL, 32'h1);
        wr(A_CMP, 32'h24);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h25);
        rd(A_CTRL, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL col_cmp_oldvalue: got %h expected %h", got, exp_v); end
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL col_cmp_cnt: got %h expected %h", got, exp_v); end
        wr(A_CTRL, 32'h100);
    endtask

    task automatic test_unselected();
        logic [31:0] regs[4];
        regs = '{A_CTRL, BASE + 32'h5, A_CNT, A_CMP};
        wr(A_PRE, 32'd7);
        wr(A_CNT, 32'h55);
        wr(A_CMP, 32'h66);
        wr(A_CTRL, 32'h106);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(BASE + 32'h10, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL unsel_rd_above: got %h expected %h", got, exp_v); end
        rd(BASE - 32'h4, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL unsel_rd_below: got %h expected %h", got, exp_v); end
        wr(BASE + 32'h10, 32'hFFFF_FFFF);
        wr(BASE + 32'h18, 32'hFFFF_FFFF);
        wr(BASE - 32'h4, 32'hFFFF_FFFF);
        wr(BASE - 32'h10, 32'hFFFF_FFFF);
        exp_q.push_back(32'h6);
        exp_q.push_back(32'h7);
        exp_q.push_back(32'h55);
        exp_q.push_back(32'h66);
        for (int i = 0; i < 4; i++) begin
            rd(regs[i], got); exp_v = exp_q.pop_front(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL unsel_keep%0d: got %h expected %h", i, got, exp_v); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] regs[4];
        regs = '{A_CTRL, A_PRE, A_CNT, A_CMP};
        wr(A_PRE, 32'd3);
        wr(A_CMP, 32'd0);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h7);
        idle(4);
        exp_q.push_back(32'h107);
        exp_q.push_back(32'd1);
        rd(A_CTRL, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL rm_ctrl_match: got %h expected %h", got, exp_v); end
        got = 32'(bus_if.irq); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL rm_irq_match: got %h expected %h", got, exp_v); end
        idle(2);
        reset = 1'b1;
        bus_if.bus_addr  = A_CNT;
        bus_if.bus_wdata = 32'h77;
        bus_if.bus_write = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_write = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(regs[i], got); exp_v = exp_q.pop_front(); n_vec++;
            if (got !== exp_v) begin n_err++; $display("FAIL rm_reg%0d: got %h expected %h", i, got, exp_v); end
        end
        got = 32'(bus_if.irq); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL rm_irq: got %h expected %h", got, exp_v); end
        idle(5);
        exp_q.push_back(32'h0);
        rd(A_CNT, got); exp_v = exp_q.pop_front(); n_vec++;
        if (got !== exp_v) begin n_err++; $display("FAIL rm_cnt_idle: got %h expected %h", got, exp_v); end
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.bus_addr  = 32'h0;
        bus_if.bus_wdata = 32'h0;
        bus_if.bus_write = 1'b0;
        test_reset();
        test_prescale_match();
        test_wrap();
        test_collisions();
        test_unselected();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
